// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid_o pulses the cycle after the 4th byte.
module byte_word_assembler
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic        wvld_q, wvld_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    wvld_d  = 1'b0;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (en_i && valid_i) begin
      shift_d = {shift_q[23:0], data_i};
      idx_d   = idx_q + 2'd1;
      wvld_d  = (idx_q == LAST_IDX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      wvld_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      wvld_q  <= wvld_d;
    end
  end

  // The completed word stays in shift_q during the valid cycle; a new byte only shifts at its end.
  assign word_o       = shift_q;
  assign word_valid_o = wvld_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a UART byte stream into instruction memory until HALT, stalling the pipeline meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require an XOR checksum byte after the HALT word.
module imem_loader #(
  parameter int          NB_ADDR     = 32,
  parameter int          NB_INST     = 32,
  parameter int          NB_ROM_SIZE = 10,
  parameter int          ADDR_STEP   = 4,
  parameter logic [31:0] HALT_WORD   = mips_pkg::HALT_WORD
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_write,
  output logic [NB_ADDR-1:0]     o_address,
  output logic [NB_INST-1:0]     o_instruction,
  output logic                   o_stall,
  output logic                   o_done,
  output logic                   o_error,
  output logic [NB_ROM_SIZE:0]   o_word_count
);

  import mips_pkg::*;

  localparam logic [NB_ROM_SIZE:0] DEPTH     = {1'b1, {NB_ROM_SIZE{1'b0}}};
  localparam logic [NB_ROM_SIZE:0] CNT_ONE   = (NB_ROM_SIZE+1)'(1);
  localparam logic [NB_ROM_SIZE:0] LAST_SLOT = DEPTH - CNT_ONE;
  localparam logic [NB_ADDR-1:0]   STEP      = NB_ADDR'(ADDR_STEP);

  state_t                 state_q, state_d;
  logic [NB_ADDR-1:0]     addr_q, addr_d;
  logic [NB_ROM_SIZE:0]   count_q, count_d;
  logic [31:0]            word;
  logic                   word_vld;
  logic                   start_acc;
  logic                   full;
  logic                   wr_en, stall, done, error;

  assign start_acc = i_start && (state_q != ST_LOAD) && (state_q != ST_CHECK);
  assign full      = (count_q == DEPTH);

  byte_word_assembler u_asm (
    .clk_i        (i_clk),
    .reset_i      (i_reset),
    .clear_i      (start_acc),
    .en_i         (state_q == ST_LOAD),
    .data_i       (i_rx_data),
    .valid_i      (i_rx_valid),
    .word_o       (word),
    .word_valid_o (word_vld)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d = xor_q;
    if (start_acc)
      xor_d = '0;
    else if (state_q == ST_LOAD && i_rx_valid)
      xor_d = xor_q ^ i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) xor_q <= '0;
    else         xor_q <= xor_d;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (i_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (word_vld) begin
          if (full)
            state_d = ST_ERROR;
          else if (word == HALT_WORD)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (i_rx_valid) state_d = (i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    stall = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    case (state_q)
      ST_LOAD: begin
        stall = 1'b1;
        wr_en = word_vld && !full;
      end
      ST_CHECK: stall = 1'b1;
      ST_DONE:  done  = 1'b1;
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // The address holds on the final slot so it never leaves the memory's range.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (start_acc) begin
      addr_d  = '0;
      count_d = '0;
    end else if (wr_en) begin
      count_d = count_q + CNT_ONE;
      if (count_q != LAST_SLOT) addr_d = addr_q + STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign o_write       = wr_en;
  assign o_address     = addr_q;
  assign o_instruction = NB_INST'(word);
  assign o_stall       = stall;
  assign o_done        = done;
  assign o_error       = error;
  assign o_word_count  = count_q;

endmodule
